// File: rtl/alu_pipe_p.sv
// alu_pipe_p -- two-stage pipelined ALU with valid/ready handshakes.
//
// Purpose:
//   Decode stage (D) captures an instruction: the function code is reduced
//   to the index of its highest set bit, or flagged as an error when it is
//   zero. Execute stage (E) computes the result from D and drives the output
//   port. Chained instructions replace operand B with the previous result.
//
// Optional feature:
//   ALU_PIPE_PARITY_EN -- when defined, out_parity is registered with the
//   result as its XNOR reduction. When undefined, out_parity is constant 0.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_fcode [7:0]     function code; highest set bit selects the operation
//   in_a, in_b         operands (WIDTH bits)
//   in_chain           use the previous result as operand B
//   out_valid/out_ready output handshake
//   out_op [2:0]       decoded operation index
//   out_result         ALU result (WIDTH bits)
//   out_carry          ADD carry-out / SUB borrow
//   out_err            function code was all zero
//   out_parity         XNOR reduction of out_result (0 when feature is off)

module alu_pipe_p #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_fcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_err,
    output logic             out_parity
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_OR   = 3'd3,
        OP_AND  = 3'd4,
        OP_NOR  = 3'd5,
        OP_NAND = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    // One advance signal moves the whole pipe; a stalled output freezes
    // both stages and the chain register together.
    logic adv;

    // Decode stage
    logic             d_valid_q, d_valid_d;
    logic             d_err_q,   d_err_d;
    logic [2:0]       d_op_q,    d_op_d;
    logic [WIDTH-1:0] d_a_q,     d_a_d;
    logic [WIDTH-1:0] d_b_q,     d_b_d;
    logic             d_chain_q, d_chain_d;

    // Execute / output stage
    logic             e_valid_q,  e_valid_d;
    logic [2:0]       e_op_q,     e_op_d;
    logic [WIDTH-1:0] e_result_q, e_result_d;
    logic             e_carry_q,  e_carry_d;
    logic             e_err_q,    e_err_d;
    logic [WIDTH-1:0] last_q,     last_d;

    logic [2:0]       dec_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res_n;
    logic             carry_n;

    assign adv      = ~e_valid_q | out_ready;
    assign in_ready = adv;

    // Priority encoder: later (higher) set bits overwrite earlier ones.
    always_comb begin
        dec_op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_fcode[i]) dec_op = 3'(i);
        end
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_err_d   = d_err_q;
        d_op_d    = d_op_q;
        d_a_d     = d_a_q;
        d_b_d     = d_b_q;
        d_chain_d = d_chain_q;
        if (adv) begin
            d_valid_d = in_valid;
            d_err_d   = (in_fcode == 8'd0);
            d_op_d    = dec_op;
            d_a_d     = in_a;
            d_b_d     = in_b;
            d_chain_d = in_chain;
        end
    end

    // Execute. The extra MSB of sum/diff is carry-out for ADD and, since
    // operands are zero-extended, the borrow (A < B) for SUB.
    always_comb begin
        b_eff   = d_chain_q ? last_q : d_b_q;
        sum     = {1'b0, d_a_q} + {1'b0, b_eff};
        diff    = {1'b0, d_a_q} - {1'b0, b_eff};
        res_n   = '0;
        carry_n = 1'b0;
        case (op_e'(d_op_q))
            OP_ADD:  {carry_n, res_n} = sum;
            OP_SUB:  {carry_n, res_n} = diff;
            OP_XOR:  res_n = d_a_q ^ b_eff;
            OP_OR:   res_n = d_a_q | b_eff;
            OP_AND:  res_n = d_a_q & b_eff;
            OP_NOR:  res_n = ~(d_a_q | b_eff);
            OP_NAND: res_n = ~(d_a_q & b_eff);
            OP_XNOR: res_n = ~(d_a_q ^ b_eff);
            default: res_n = '0;
        endcase
        if (d_err_q) begin
            res_n   = '0;
            carry_n = 1'b0;
        end
    end

    always_comb begin
        e_valid_d  = e_valid_q;
        e_op_d     = e_op_q;
        e_result_d = e_result_q;
        e_carry_d  = e_carry_q;
        e_err_d    = e_err_q;
        last_d     = last_q;
        if (adv) begin
            e_valid_d  = d_valid_q;
            e_op_d     = d_op_q;
            e_result_d = res_n;
            e_carry_d  = carry_n;
            e_err_d    = d_err_q;
            // Bubbles leave the chain operand alone; error results write 0.
            if (d_valid_q) last_d = res_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_op_q     <= 3'd0;
            d_a_q      <= '0;
            d_b_q      <= '0;
            d_chain_q  <= 1'b0;
            e_valid_q  <= 1'b0;
            e_op_q     <= 3'd0;
            e_result_q <= '0;
            e_carry_q  <= 1'b0;
            e_err_q    <= 1'b0;
            last_q     <= '0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_err_q    <= d_err_d;
            d_op_q     <= d_op_d;
            d_a_q      <= d_a_d;
            d_b_q      <= d_b_d;
            d_chain_q  <= d_chain_d;
            e_valid_q  <= e_valid_d;
            e_op_q     <= e_op_d;
            e_result_q <= e_result_d;
            e_carry_q  <= e_carry_d;
            e_err_q    <= e_err_d;
            last_q     <= last_d;
        end
    end

`ifdef ALU_PIPE_PARITY_EN
    // Parity of the zero result after reset is even, hence reset value 1.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (adv) parity_d = ~^res_n;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b1;
        else       parity_q <= parity_d;
    end

    assign out_parity = parity_q;
`else
    assign out_parity = 1'b0;
`endif

    assign out_valid  = e_valid_q;
    assign out_op     = e_op_q;
    assign out_result = e_result_q;
    assign out_carry  = e_carry_q;
    assign out_err    = e_err_q;

endmodule

// File: tb/tb_alu_pipe_p.sv
// Self-checking bench for alu_pipe_p (WIDTH = 4). A negedge monitor keeps a
// scoreboard: a reference model result is pushed when an instruction is
// accepted and popped/compared when the output is consumed. Each scenario
// task also checks its own directed values inline.

module tb_alu_pipe_p;

    localparam int W = 4;
    localparam int M = 1 << W;

`ifdef ALU_PIPE_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_fcode;
    logic [W-1:0] in_a, in_b;
    logic         in_chain;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_op;
    logic [W-1:0] out_result;
    logic         out_carry, out_err, out_parity;

    always #5 clk = ~clk;

    alu_pipe_p #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fcode(in_fcode), .in_a(in_a), .in_b(in_b), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_result(out_result), .out_carry(out_carry),
        .out_err(out_err), .out_parity(out_parity)
    );

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         carry;
        logic         err;
        logic         par;
    } exp_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    exp_t   sb[$];
    exp_t   obs[$];
    logic [W-1:0] m_last = '0;

    // Reference model, written arithmetically on integers.
    function automatic exp_t model(input logic [7:0] fc, input logic [W-1:0] a,
                                   input logic [W-1:0] b_in, input logic chain);
        exp_t e;
        int   ia, ib, s;
        logic [W-1:0] b;
        bit   found;
        b = chain ? m_last : b_in;
        e = '0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && fc[i]) begin e.op = 3'(i); found = 1'b1; end
        end
        ia = int'(a);
        ib = int'(b);
        if (!found) begin
            e.err = 1'b1;
        end else begin
            case (e.op)
                3'd0: begin s = ia + ib; e.res = W'(s % M); e.carry = (s >= M); end
                3'd1: begin s = ia - ib + M; e.res = W'(s % M); e.carry = (ia < ib); end
                3'd2: e.res = a ^ b;
                3'd3: e.res = a | b;
                3'd4: e.res = a & b;
                3'd5: e.res = ~(a | b);
                3'd6: e.res = ~(a & b);
                default: e.res = ~(a ^ b);
            endcase
        end
        e.par = PAR_EN ? ~^e.res : 1'b0;
        return e;
    endfunction

    // Scoreboard monitor: pop before push so a same-cycle accept never
    // satisfies its own output.
    always @(negedge clk) begin
        exp_t e, g;
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_chk++;
                g = '{out_op, out_result, out_carry, out_err, out_parity};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got op=%0d res=%h with nothing expected",
                             out_op, out_result);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got op=%0d res=%h c=%b e=%b p=%b, want op=%0d res=%h c=%b e=%b p=%b",
                                 g.op, g.res, g.carry, g.err, g.par,
                                 e.op, e.res, e.carry, e.err, e.par);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_fcode, in_a, in_b, in_chain);
                sb.push_back(e);
                m_last = e.res;
            end
        end
    end

    // Present one instruction and return just after the edge that takes it.
    task automatic send(input logic [7:0] fc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic chain);
        int t = 0;
        in_valid = 1'b1; in_fcode = fc; in_a = a; in_b = b; in_chain = chain;
        do begin @(negedge clk); t++; end while (!in_ready && t < 50);
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b, want 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Gather n consumed outputs (out_ready held 1 by the caller).
    task automatic collect(input int n);
        int t = 0;
        while (obs.size() < n && t < 40) begin
            @(posedge clk); #1; t++;
            if (out_valid) obs.push_back('{out_op, out_result, out_carry, out_err, out_parity});
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_last = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({out_valid, out_op, out_result, out_carry, out_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: v=%b op=%0d res=%h c=%b e=%b, want all 0",
                     out_valid, out_op, out_result, out_carry, out_err);
        end
        n_chk++;
        if (out_parity !== PAR_EN) begin
            n_fail++;
            $display("FAIL reset_parity: got %b want %b", out_parity, PAR_EN);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        send(8'h01, 4'h1, 4'hA, 1'b0);
        idle();
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_latency_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid, out_op, out_result, out_carry, out_err, out_parity} !==
            {1'b1, 3'd0, 4'hB, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_result: v=%b op=%0d res=%h c=%b e=%b p=%b, want v=1 op=0 res=b c=0 e=0 p=0",
                     out_valid, out_op, out_result, out_carry, out_err, out_parity);
        end
        wait_drain();
    endtask

    task automatic test_priority_sub();
        obs.delete();
        fork
            collect(2);
            begin
                send(8'h13, 4'h2, 4'hA, 1'b0);
                send(8'h02, 4'h2, 4'hA, 1'b0);
                idle();
            end
        join
        n_chk++;
        if (obs.size() != 2) begin
            n_fail++;
            $display("FAIL prio_count: got %0d results want 2", obs.size());
        end else begin
            n_chk++;
            if (obs[0].op !== 3'd4 || obs[0].res !== 4'h2 || obs[0].carry !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_and: op=%0d res=%h c=%b want op=4 res=2 c=0",
                         obs[0].op, obs[0].res, obs[0].carry);
            end
            n_chk++;
            if (obs[1].op !== 3'd1 || obs[1].res !== 4'h8 || obs[1].carry !== 1'b1) begin
                n_fail++;
                $display("FAIL sub_borrow: op=%0d res=%h c=%b want op=1 res=8 c=1",
                         obs[1].op, obs[1].res, obs[1].carry);
            end
        end
        wait_drain();
    endtask

    task automatic test_error();
        obs.delete();
        fork
            collect(2);
            begin
                send(8'h00, 4'hF, 4'hF, 1'b0);
                send(8'h01, 4'h3, 4'h9, 1'b1);
                idle();
            end
        join
        n_chk++;
        if (obs.size() != 2) begin
            n_fail++;
            $display("FAIL err_count: got %0d results want 2", obs.size());
        end else begin
            n_chk++;
            if (obs[0].err !== 1'b1 || obs[0].res !== 4'h0 || obs[0].op !== 3'd0 || obs[0].carry !== 1'b0) begin
                n_fail++;
                $display("FAIL err_flag: e=%b res=%h op=%0d c=%b want e=1 res=0 op=0 c=0",
                         obs[0].err, obs[0].res, obs[0].op, obs[0].carry);
            end
            n_chk++;
            if (obs[1].err !== 1'b0 || obs[1].res !== 4'h3) begin
                n_fail++;
                $display("FAIL err_chain: e=%b res=%h want e=0 res=3", obs[1].err, obs[1].res);
            end
        end
        wait_drain();
    endtask

    task automatic test_chain();
        logic [W-1:0] want [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        obs.delete();
        fork
            collect(4);
            begin
                send(8'h01, 4'h1, 4'h0, 1'b0);
                send(8'h01, 4'h1, 4'h7, 1'b1);
                idle();
                @(posedge clk); #1;
                send(8'h01, 4'h1, 4'h7, 1'b1);
                send(8'h01, 4'h1, 4'h7, 1'b1);
                idle();
            end
        join
        n_chk++;
        if (obs.size() != 4) begin
            n_fail++;
            $display("FAIL chain_count: got %0d results want 4", obs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (obs[k].res !== want[k]) begin
                    n_fail++;
                    $display("FAIL chain_acc[%0d]: got %h want %h", k, obs[k].res, want[k]);
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        fork
            begin
                send(8'h01, 4'h1, 4'h1, 1'b0);
                send(8'h01, 4'h2, 4'h3, 1'b0);
                send(8'h01, 4'h4, 4'h4, 1'b0);
                send(8'h01, 4'h7, 4'h7, 1'b0);
                idle();
            end
            begin
                logic [W-1:0] held;
                int t = 0;
                while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
                out_ready = 1'b0;
                held = out_result;
                repeat (3) begin
                    @(negedge clk);
                    n_chk++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: in_ready=%b v=%b res=%h, want in_ready=0 v=1 res=%h",
                                 in_ready, out_valid, out_result, held);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'h01, 4'h3, 4'h4, 1'b0);
        send(8'h01, 4'h5, 4'h5, 1'b0);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_last = '0;
        out_ready = 1'b1;
        n_chk++;
        if ({out_valid, out_op, out_result, out_carry, out_err, out_parity} !==
            {1'b0, 3'd0, 4'h0, 1'b0, 1'b0, PAR_EN}) begin
            n_fail++;
            $display("FAIL midreset_outputs: v=%b op=%0d res=%h c=%b e=%b p=%b, want reset values",
                     out_valid, out_op, out_result, out_carry, out_err, out_parity);
        end
        repeat (2) begin
            @(posedge clk); #1;
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale: out_valid=%b want 0", out_valid);
            end
        end
        obs.delete();
        fork
            collect(1);
            begin send(8'h01, 4'h5, 4'h9, 1'b1); idle(); end
        join
        n_chk++;
        if (obs.size() != 1 || obs[0].res !== 4'h5) begin
            n_fail++;
            $display("FAIL midreset_chain: got %0d results, first res=%h, want one result 5",
                     obs.size(), (obs.size() > 0) ? obs[0].res : 4'hx);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit running = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [7:0] fc;
                    fc = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                    send(fc, W'($urandom), W'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
                end
                idle();
                running = 1'b0;
            end
            begin
                while (running) begin
                    out_ready = 1'($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_fcode = '0; in_a = '0; in_b = '0;
        in_chain = 1'b0; out_ready = 1'b1;
        test_reset();
        test_add();
        test_priority_sub();
        test_error();
        test_chain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
